// File: rtl/challenge_auth_streamer.sv
// CHALLENGE request -> validate -> fetch slot digest -> stream CHALLENGE_AUTH
// response OUT_W bits per beat, MSB first.
`ifndef PROTOCOL_VERSION
`define PROTOCOL_VERSION 8'h01
`endif
`ifndef CHALLENGE_AUTH_CMD
`define CHALLENGE_AUTH_CMD 8'h03
`endif
`ifndef CERT_CHAINS_MASK
`define CERT_CHAINS_MASK 8'h01
`endif
`ifndef CAPABILITIES
`define CAPABILITIES 8'h01
`endif

module challenge_auth_streamer #(
  parameter int         MSG_W       = 256,
  parameter int         NUM_SLOTS   = 8,
  parameter logic [7:0] SLOT_MASK   = 8'h01,
  parameter int         HASH_W      = 256,
  parameter int         OUT_W       = 8,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic              clk_i,
  input  logic              reset_L_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [MSG_W-1:0]  req_msg_i,
  output logic              dig_req_o,
  output logic [2:0]        dig_slot_o,
  output logic [MSG_W-33:0] dig_nonce_o,
  input  logic              dig_ack_i,
  input  logic [HASH_W-1:0] dig_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [OUT_W-1:0]  rsp_data_o,
  output logic              rsp_last_o,
  output logic              err_valid_o,
  output logic [1:0]        err_code_o,
  output logic              busy_o
);
  localparam int RSP_W = 64 + HASH_W;
  localparam int BEATS = RSP_W / OUT_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(TIMEOUT_CYC);
  localparam logic [7:0]    SLOTS8 = 8'(NUM_SLOTS);
  localparam logic [BW-1:0] LAST_B = BW'(BEATS - 1);
  localparam logic [CW-1:0] LAST_C = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIGEST, S_SEND, S_ERROR} state_e;

  state_e            state_q, state_d;
  logic [7:0]        ver_q, ver_d, slot_q, slot_d;
  logic [MSG_W-33:0] nonce_q, nonce_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [RSP_W-1:0]  rsp_q, rsp_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              bad_req, bad_slot;

  always_ff @(posedge clk_i) begin
    if (!reset_L_i) begin
      state_q    <= S_IDLE;
      ver_q      <= '0;
      slot_q     <= '0;
      nonce_q    <= '0;
      cnt_q      <= '0;
      beat_q     <= '0;
      rsp_q      <= '0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      ver_q      <= ver_d;
      slot_q     <= slot_d;
      nonce_q    <= nonce_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      rsp_q      <= rsp_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ver_d      = ver_q;
    slot_d     = slot_q;
    nonce_d    = nonce_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    rsp_d      = rsp_q;
    err_code_d = err_code_q;
    bad_req    = (ver_q != `PROTOCOL_VERSION) || (nonce_q == '0);
    // range check first so the mask lookup only matters for in-range slots
    bad_slot   = (slot_q >= SLOTS8) || !SLOT_MASK[slot_q[2:0]];
    unique case (state_q)
      S_IDLE: if (req_valid_i) begin
        ver_d   = req_msg_i[31:24];
        slot_d  = req_msg_i[15:8];
        nonce_d = req_msg_i[MSG_W-1:32];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bad_req) begin
          err_code_d = 2'b01;
          state_d    = S_ERROR;
        end else if (bad_slot) begin
          err_code_d = 2'b10;
          state_d    = S_ERROR;
        end else begin
          cnt_d   = '0;
          state_d = S_DIGEST;
        end
      end
      S_DIGEST: begin
        // an ack on the final timeout cycle still wins
        if (dig_ack_i) begin
          rsp_d   = {`PROTOCOL_VERSION, `CHALLENGE_AUTH_CMD, slot_q, `CERT_CHAINS_MASK,
                     `PROTOCOL_VERSION, `PROTOCOL_VERSION, `CAPABILITIES, 8'h00, dig_data_i};
          beat_d  = '0;
          state_d = S_SEND;
        end else if (cnt_q == LAST_C) begin
          err_code_d = 2'b11;
          state_d    = S_ERROR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SEND: if (rsp_ready_i) begin
        rsp_d  = rsp_q << OUT_W;
        beat_d = beat_q + BW'(1);
        if (beat_q == LAST_B) state_d = S_IDLE;
      end
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign dig_req_o   = (state_q == S_DIGEST);
  assign dig_slot_o  = dig_req_o ? slot_q[2:0] : 3'd0;
  assign dig_nonce_o = dig_req_o ? nonce_q : '0;
  assign rsp_valid_o = (state_q == S_SEND);
  assign rsp_data_o  = rsp_q[RSP_W-1 -: OUT_W];
  assign rsp_last_o  = rsp_valid_o && (beat_q == LAST_B);
  assign err_valid_o = (state_q == S_ERROR);
  assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_challenge_auth_streamer.sv
// Scoreboard bench: driver pushes expected beats/errors from a byte-level
// model, negedge monitor pops and compares whatever the DUT presents.
module tb_challenge_auth_streamer;
  localparam int MSG_W = 256, NW = MSG_W - 32, NUM_SLOTS = 8, HASH_W = 256, OUT_W = 8, TO = 16;
  localparam logic [7:0] MASK = 8'h05;
  localparam logic [7:0] VER = 8'h01, CMD = 8'h03, CCM = 8'h01, CAP = 8'h01;
  localparam int BEATS = (64 + HASH_W) / OUT_W;

  typedef struct {bit is_err; logic [1:0] code; logic [7:0] data; bit last;} exp_t;

  logic clk = 0, reset_L = 0;
  logic req_valid = 0, req_ready;
  logic [MSG_W-1:0] req_msg = '0;
  logic dig_req, dig_ack = 0;
  logic [2:0] dig_slot;
  logic [NW-1:0] dig_nonce;
  logic [HASH_W-1:0] dig_data = '0;
  logic rsp_valid, rsp_ready = 1, rsp_last, err_valid, busy;
  logic [OUT_W-1:0] rsp_data;
  logic [1:0] err_code;

  exp_t exp_q[$];
  int n_chk = 0, n_err = 0, beats_popped = 0;
  bit stall_mode = 0, stalled_prev = 0;
  logic [7:0] prev_data;
  logic prev_last;
  logic [1:0] last_code = 2'b00;

  challenge_auth_streamer #(.MSG_W(MSG_W), .NUM_SLOTS(NUM_SLOTS), .SLOT_MASK(MASK),
    .HASH_W(HASH_W), .OUT_W(OUT_W), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .reset_L_i(reset_L), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_msg_i(req_msg), .dig_req_o(dig_req), .dig_slot_o(dig_slot), .dig_nonce_o(dig_nonce),
    .dig_ack_i(dig_ack), .dig_data_i(dig_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_last_o(rsp_last), .err_valid_o(err_valid), .err_code_o(err_code),
    .busy_o(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    rsp_ready = stall_mode ? 1'($urandom % 2) : 1'b1;
  end

  // monitor
  always @(negedge clk) if (reset_L) begin
    exp_t it;
    if (err_valid) begin
      if (exp_q.size() == 0) chk("unexpected_err", {254'd0, err_code}, 256'd0);
      else begin
        it = exp_q.pop_front();
        chk("err_kind", 1'b1, it.is_err);
        chk("err_code", err_code, it.code);
      end
    end
    if (rsp_valid) begin
      if (stalled_prev) begin
        chk("stall_data", rsp_data, prev_data);
        chk("stall_last", rsp_last, prev_last);
      end
      if (rsp_ready) begin
        stalled_prev = 0;
        beats_popped++;
        if (exp_q.size() == 0) chk("unexpected_beat", {248'd0, rsp_data}, 256'd0);
        else begin
          it = exp_q.pop_front();
          chk("beat_kind", 1'b0, it.is_err);
          chk("beat_data", rsp_data, it.data);
          chk("beat_last", rsp_last, it.last);
        end
      end else begin
        stalled_prev = 1;
        prev_data = rsp_data;
        prev_last = rsp_last;
      end
    end else stalled_prev = 0;
  end

  function automatic logic [HASH_W-1:0] rand_hash();
    logic [HASH_W-1:0] h;
    for (int i = 0; i < HASH_W / 32; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  task automatic push_err(input logic [1:0] c);
    exp_t it;
    it = '{1'b1, c, 8'h00, 1'b0};
    exp_q.push_back(it);
    last_code = c;
  endtask

  task automatic push_beats(input logic [7:0] slot, input logic [HASH_W-1:0] dig);
    logic [64+HASH_W-1:0] r;
    exp_t it;
    r = {VER, CMD, slot, CCM, VER, VER, CAP, 8'h00, dig};
    for (int i = 0; i < BEATS; i++) begin
      it = '{1'b0, 2'b00, r[64+HASH_W-1-8*i -: 8], (i == BEATS - 1)};
      exp_q.push_back(it);
    end
  endtask

  // d: index of the dig_req cycle carrying the ack (>= TO means never)
  task automatic run_txn(input logic [7:0] ver, input logic [7:0] slot, input logic [NW-1:0] nonce,
                         input int d, input bit stall, input int abort_at);
    logic [HASH_W-1:0] dig;
    bit bad_req, bad_slot;
    int k, n, base;
    dig = rand_hash();
    stall_mode = stall;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("ready_before_req", req_ready, 1'b1);
    bad_req  = (ver != VER) || (nonce == '0);
    bad_slot = (slot >= NUM_SLOTS) || !MASK[slot[2:0]];
    if (bad_req) push_err(2'b01);
    else if (bad_slot) push_err(2'b10);
    else if (d >= TO) push_err(2'b11);
    else push_beats(slot, dig);
    base = beats_popped;
    req_msg = {nonce, ver, 8'h83, slot, 8'($urandom)};
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    req_msg = {rand_hash()};
    @(negedge clk);
    chk("check_busy", busy, 1'b1);
    chk("check_no_digreq", dig_req, 1'b0);
    @(negedge clk);
    if (bad_req || bad_slot) begin
      chk("err_pulse_cyc2", err_valid, 1'b1);
      chk("err_no_digreq", dig_req, 1'b0);
      @(negedge clk);
      chk("err_ready_cyc3", req_ready, 1'b1);
      chk("err_code_held", err_code, last_code);
      return;
    end
    chk("digreq_cyc2", dig_req, 1'b1);
    chk("dig_slot", dig_slot, slot[2:0]);
    chk("dig_nonce", dig_nonce, nonce);
    k = 0;
    while (dig_req && k < TO + 2) begin
      if (k == d) begin dig_ack = 1; dig_data = dig; end
      @(posedge clk); #1;
      dig_ack = 0;
      dig_data = rand_hash();
      k++;
      @(negedge clk);
    end
    if (d >= TO) begin
      chk("timeout_cycles", k, TO);
      chk("timeout_err_pulse", err_valid, 1'b1);
    end else begin
      chk("ack_cycles", k, d + 1);
      chk("first_beat_valid", rsp_valid, 1'b1);
    end
    if (abort_at >= 0) begin
      #1;
      n = 0;
      while (beats_popped - base < abort_at + 1 && n < 200) begin @(negedge clk); #1; n++; end
      chk("abort_reached", n < 200, 1'b1);
      reset_L = 0;
      exp_q.delete();
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_rsp_valid", rsp_valid, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_req_ready", req_ready, 1'b1);
      chk("abort_dig_req", dig_req, 1'b0);
      chk("abort_rsp_data", rsp_data, 8'h00);
      reset_L = 1;
      last_code = 2'b00;
      return;
    end
    n = 0;
    while (!(req_ready && exp_q.size() == 0) && n < 3000) begin @(negedge clk); n++; end
    chk("txn_done", n < 3000, 1'b1);
    chk("err_code_held", err_code, last_code);
  endtask

  initial begin
    logic [NW-1:0] nz;
    logic [7:0] v, s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dig_req", dig_req, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_last", rsp_last, 1'b0);
    chk("rst_err_valid", err_valid, 1'b0);
    chk("rst_err_code", err_code, 2'b00);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_dig_slot", dig_slot, 3'd0);
    chk("rst_dig_nonce", dig_nonce, '0);
    reset_L = 1;
    @(negedge clk);

    run_txn(VER, 8'd0, NW'(1), 1, 0, -1);    // nominal
    run_txn(VER, 8'd0, '0, 0, 0, -1);        // zero nonce
    run_txn(8'h02, 8'd3, NW'(5), 0, 0, -1);  // bad version beats bad slot
    run_txn(VER, 8'd3, NW'(7), 0, 0, -1);    // unprovisioned
    run_txn(VER, 8'd9, NW'(7), 0, 0, -1);    // out of range
    run_txn(VER, 8'd2, NW'(9), 99, 0, -1);   // timeout
    run_txn(VER, 8'd2, NW'(9), TO - 1, 0, -1); // ack on last allowed cycle
    run_txn(VER, 8'd0, NW'(1), 0, 1, -1);    // backpressure
    run_txn(VER, 8'd0, NW'(3), 1, 0, 10);    // reset mid-stream
    run_txn(VER, 8'd2, NW'(4), 2, 0, -1);    // recovery

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NW / 32; i++) nz[i*32 +: 32] = $urandom;
      if ($urandom % 8 == 0) nz = '0;
      v = ($urandom % 8 == 0) ? 8'($urandom) : VER;
      s = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom % NUM_SLOTS);
      run_txn(v, s, nz, ($urandom % 10 == 0) ? TO + int'($urandom % 4) : int'($urandom % TO),
              1'($urandom % 2), -1);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
